iiitb_param_sync_fifo: RTL and testbench
========================================

# iiitb_param_sync_fifo

Parametrised single-clock FIFO, the successor to the team's fixed 16x8 synchronous FIFO. Data width and depth are configurable. It adds a fill-level count, programmable almost-full and almost-empty flags, and protected accesses with overflow and underflow error pulses. It sits between same-clock producer and consumer blocks wherever rate smoothing or back-pressure flags are needed.

## Interface
Parameters:
- WIDTH, default 8: data word width in bits, ≥1.
- DEPTH, default 16: number of entries; must be a power of two, ≥2.
- AF_LEVEL, default DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, default 2: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- Derived AW = log2(DEPTH); not user-set.

Ports:
- CLK, input, 1: single clock, rising edge.
- RSTn, input, 1: asynchronous, active-low reset.
- write, input, 1: write request.
- read, input, 1: read request.
- iData, input, WIDTH: write data.
- oData, output, WIDTH: registered read data.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count ≥ AF_LEVEL.
- almost_empty, output, 1: count ≤ AE_LEVEL.
- count, output, AW+1: current number of stored entries, 0..DEPTH.
- overflow, output, 1: one-cycle pulse after a write rejected because the FIFO was full.
- underflow, output, 1: one-cycle pulse after a read rejected because the FIFO was empty.

## Operation
- Pointers wp and rp are AW+1 bits wide. RAM index is ptr[AW-1:0]; the MSB is the wrap bit. Both pointers wrap naturally modulo 2·DEPTH.
- count = wp − rp, modulo 2^(AW+1). full, empty, almost_full and almost_empty are combinational from count only, with no request-dependent terms.
- Write accept: wr_en = write & ~full. On wr_en, RAM[wp] <= iData and wp <= wp+1.
- Read accept: rd_en = read & ~empty. On rd_en, oData <= RAM[rp] and rp <= rp+1. Otherwise oData holds its value.
- Simultaneous write and read:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Empty: the write is accepted, the read is rejected (underflow pulses), and count becomes 1.
  - Full: the read is accepted, the write is rejected (overflow pulses), and count becomes DEPTH−1.
- A rejected access changes no pointer, no RAM entry and not oData.
- overflow <= write & full and underflow <= read & empty, registered each cycle. They are pulses, not sticky.
- RAM contents are not reset. A read is never accepted before the entry has been written.

## Timing
- Reset (RSTn low, asynchronous) sets:
  - wp, rp, count, oData to 0;
  - empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL≥1);
  - overflow=0, underflow=0.
- Reset takes effect immediately and mid-operation. All queued data is discarded.
- Reset release is synchronous to the next CLK edge; the first access is accepted on the first edge after RSTn rises.
- Write-to-flag latency: flags and count update in the cycle after the accepting edge.
- Write-to-read latency:
  - A word written at edge N makes empty fall after N.
  - A read request at edge N+1 or later is accepted.
  - The data appears on oData after that read edge, so read-data latency is 1 cycle.
- overflow and underflow are valid for exactly one cycle, following the edge that sampled the rejected request.
- Sustained rate is one write and one read per cycle.

## Structure
- Shared package iiitb_fifo_pkg holds:
  - default WIDTH/DEPTH constants;
  - a constant log2 function used to derive AW.
- Sub-module iiitb_fifo_ram is a simple dual-port memory of DEPTH×WIDTH:
  - synchronous write port (we, waddr, wdata);
  - registered read port (re, raddr, rdata) that holds its output when re=0.
- The top level holds the pointers, count, flags and error pulses.

## Test plan
- Reset and empty read: assert RSTn=0 mid-stream, then read=1 for 1 cycle -> all outputs at reset values, underflow=1 for one cycle, rp stays 0, oData=0.
- Fill and drain (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2): write 0x00..0x0F -> almost_empty falls when count reaches 3, almost_full rises at count=14, full at 16. Then read 16 times -> oData sequence 0x00..0x0F, empty after the last read.
- Overflow: with the FIFO full, write 0xAA -> overflow pulses once, count stays 16. A subsequent drain returns no 0xAA.
- Simultaneous at boundaries:
  - empty, write 0x55 with read -> count=1, underflow=1;
  - full, write with read -> oData is the oldest word, count=15, overflow=1;
  - half-full, write with read for 40 cycles -> count constant, data order preserved.
- Wrap-around: run 100 random-gap writes/reads with DEPTH=4, WIDTH=12 against a reference queue model -> oData, count and flags match every cycle across repeated pointer-MSB wraps.
- Reset mid-operation: with count=9, pulse RSTn low for a partial cycle -> immediate empty=1, count=0. The next write is read back correctly.

Source files
------------

// File: rtl/iiitb_fifo_pkg.sv
// ---------------------------------------------------------------------------
// iiitb_fifo_pkg
// Shared constants and helpers for the parametrised synchronous FIFO family.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default geometry (8-bit words, 16 entries)
//   clog2()                       : constant ceiling-log2, used to size the
//                                   RAM address and the FIFO pointers
// ---------------------------------------------------------------------------
package iiitb_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Smallest n such that 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/iiitb_fifo_ram.sv
// ---------------------------------------------------------------------------
// iiitb_fifo_ram
// Simple dual-port DEPTH x WIDTH storage for the FIFO.
//   CLK, RSTn        : clock (rising edge), async active-low reset
//   we, waddr, wdata : synchronous write port
//   re, raddr, rdata : registered read port; rdata holds when re = 0
// The storage array itself is never reset; only the read register is, so
// that the FIFO output comes out of reset as zero.
// ---------------------------------------------------------------------------
module iiitb_fifo_ram
  import iiitb_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/iiitb_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// iiitb_param_sync_fifo
// Parametrised single-clock FIFO with fill count, programmable almost flags
// and protected accesses (rejected accesses raise one-cycle error pulses).
//   Parameters: WIDTH, DEPTH (power of two >= 2), AF_LEVEL, AE_LEVEL
//   CLK, RSTn             : clock (rising edge), async active-low reset
//   write, iData          : write request and data
//   read, oData           : read request and registered read data
//   full, empty           : count == DEPTH / count == 0
//   almost_full           : count >= AF_LEVEL
//   almost_empty          : count <= AE_LEVEL
//   count                 : number of stored entries, 0..DEPTH
//   overflow, underflow   : pulse after a write-when-full / read-when-empty
// ---------------------------------------------------------------------------
module iiitb_param_sync_fifo
  import iiitb_fifo_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oData,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] AF_CNT   = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_CNT   = AE_LEVEL[AW:0];

  // Pointers carry one extra wrap bit so that full (difference DEPTH) and
  // empty (difference 0) are distinguishable from the subtraction alone.
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        wr_en;
  logic        rd_en;

  assign count = wp - rp;

  // Flags depend on the stored count only, never on this cycle's requests,
  // so producers and consumers can use them without combinational loops.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign wr_en = write & ~full;
  assign rd_en = read & ~empty;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) begin
        wp <= wp + 1'b1;
      end
      if (rd_en) begin
        rp <= rp + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write & full;
      underflow <= read & empty;
    end
  end

  // A read is only accepted when count > 0 and a write only when
  // count < DEPTH, so both ports never address the same entry in the same
  // cycle; no read-during-write bypass is needed.
  iiitb_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .we    (wr_en),
    .waddr (wp[AW-1:0]),
    .wdata (iData),
    .re    (rd_en),
    .raddr (rp[AW-1:0]),
    .rdata (oData)
  );

endmodule

// File: tb/tb_iiitb_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_iiitb_param_sync_fifo
// Self-checking bench for iiitb_param_sync_fifo. Two instances are built:
//   dut_a : WIDTH=8,  DEPTH=16, AF_LEVEL=14, AE_LEVEL=2
//   dut_b : WIDTH=12, DEPTH=4,  AF_LEVEL=3,  AE_LEVEL=1
// Only the selected instance receives requests; both share clock and reset.
// ---------------------------------------------------------------------------
module tb_iiitb_param_sync_fifo;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;

  always #5 CLK = ~CLK;

  // Common stimulus, steered to the selected instance.
  bit          sel;
  logic        wr;
  logic        rd;
  logic [11:0] din;

  logic       wr_a, rd_a;
  logic [7:0] din_a, dout_a;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [4:0] count_a;

  logic        wr_b, rd_b;
  logic [11:0] din_b, dout_b;
  logic        full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [2:0]  count_b;

  assign wr_a  = wr & ~sel;
  assign rd_a  = rd & ~sel;
  assign din_a = din[7:0];
  assign wr_b  = wr & sel;
  assign rd_b  = rd & sel;
  assign din_b = din;

  iiitb_param_sync_fifo #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut_a (
    .CLK(CLK), .RSTn(RSTn), .write(wr_a), .read(rd_a), .iData(din_a),
    .oData(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a)
  );

  iiitb_param_sync_fifo #(
    .WIDTH(12), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut_b (
    .CLK(CLK), .RSTn(RSTn), .write(wr_b), .read(rd_b), .iData(din_b),
    .oData(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b)
  );

  // Observed outputs of the selected instance.
  logic [11:0] act_data;
  int          act_count;
  logic        act_full, act_empty, act_af, act_ae, act_ovf, act_udf;

  always_comb begin
    act_data  = sel ? dout_b : {4'h0, dout_a};
    act_count = sel ? int'(count_b) : int'(count_a);
    act_full  = sel ? full_b  : full_a;
    act_empty = sel ? empty_b : empty_a;
    act_af    = sel ? af_b    : af_a;
    act_ae    = sel ? ae_b    : ae_a;
    act_ovf   = sel ? ovf_b   : ovf_a;
    act_udf   = sel ? udf_b   : udf_a;
  end

  // Reference model: queue of stored words plus expected registered outputs.
  logic [11:0] mq[$];
  int          md, maf, mae;
  logic [11:0] wmask;
  logic [11:0] exp_data;
  bit          exp_ovf, exp_udf;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic        w;
    logic        r;
    logic [11:0] d;
    int          cnt;
    bit          f, e, af, ae, ovf, udf;
  } vec_t;

  vec_t tbl[12];

  task automatic checkField(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("[TB] FAIL %s (sel=%0d t=%0t): got %0h, expected %0h", name, sel, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input int ec, input bit ef, input bit ee,
                             input bit eaf, input bit eae,
                             input bit eovf, input bit eudf);
    checkField("count", act_count, ec);
    checkField("full", int'(act_full), int'(ef));
    checkField("empty", int'(act_empty), int'(ee));
    checkField("almost_full", int'(act_af), int'(eaf));
    checkField("almost_empty", int'(act_ae), int'(eae));
    checkField("overflow", int'(act_ovf), int'(eovf));
    checkField("underflow", int'(act_udf), int'(eudf));
    checkField("oData", int'(act_data), int'(exp_data));
  endtask

  // Updates the model for one cycle, drives the requests across one rising
  // edge and returns at the following falling edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [11:0] d);
    int c;
    c = mq.size();
    exp_ovf = w && (c == md);
    exp_udf = r && (c == 0);
    if (r && c > 0) exp_data = mq.pop_front();
    if (w && c < md) mq.push_back(d & wmask);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge CLK);
    @(negedge CLK);
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic stepModel(input logic w, input logic r, input logic [11:0] d);
    int c;
    applyStimulus(w, r, d);
    c = mq.size();
    checkOutput(c, c == md, c == 0, c >= maf, c <= mae, exp_ovf, exp_udf);
  endtask

  // Short low pulse between clock edges; outputs are checked while the
  // reset is still asserted to confirm it acts asynchronously.
  task automatic resetPulse();
    #1 RSTn = 1'b0;
    mq.delete();
    exp_data = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    #1 checkOutput(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic selectDut(input bit s);
    sel = s;
    if (s) begin
      md = 4;  maf = 3;  mae = 1; wmask = 12'hFFF;
    end else begin
      md = 16; maf = 14; mae = 2; wmask = 12'h0FF;
    end
    resetPulse();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wr = 1'b0; rd = 1'b0; din = '0; sel = 1'b1;
    // w, r, data, count, full, empty, af, ae, ovf, udf  (DEPTH=4, AF=3, AE=1)
    tbl[0]  = '{1'b0, 1'b1, 12'h000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 12'h155, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 12'h2AA, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 12'h3C3, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 12'h0F0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 12'hBAD, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 12'h777, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 12'h000, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 12'h000, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 12'h000, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 12'h000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 0, 12'h000, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    @(negedge CLK);
    @(negedge CLK);

    // Small instance: hand-derived boundary table; read data via the model.
    $display("[TB] table vectors on DEPTH=4 instance");
    selectDut(1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].w, tbl[i].r, tbl[i].d);
      checkOutput(tbl[i].cnt, tbl[i].f, tbl[i].e, tbl[i].af, tbl[i].ae,
                  tbl[i].ovf, tbl[i].udf);
    end

    // Large instance: reset-state read, fill/drain, overflow, boundaries.
    $display("[TB] fill, drain and boundary sequences on DEPTH=16 instance");
    selectDut(1'b0);
    stepModel(1'b0, 1'b1, 12'h0);
    stepModel(1'b0, 1'b0, 12'h0);
    for (int i = 0; i < 16; i++) stepModel(1'b1, 1'b0, 12'(i));
    stepModel(1'b1, 1'b0, 12'hAA);
    stepModel(1'b0, 1'b0, 12'h0);
    for (int i = 0; i < 16; i++) stepModel(1'b0, 1'b1, 12'h0);
    stepModel(1'b0, 1'b1, 12'h0);
    stepModel(1'b1, 1'b1, 12'h55);
    for (int i = 0; i < 15; i++) stepModel(1'b1, 1'b0, 12'(8'h60 + i));
    stepModel(1'b1, 1'b1, 12'hEE);
    for (int i = 0; i < 7; i++) stepModel(1'b0, 1'b1, 12'h0);
    for (int i = 0; i < 40; i++) stepModel(1'b1, 1'b1, 12'(8'h80 + i));
    stepModel(1'b1, 1'b0, 12'hC1);

    // Reset with nine entries stored, then a clean write/read round trip.
    $display("[TB] reset mid-operation");
    resetPulse();
    stepModel(1'b1, 1'b0, 12'h3C);
    stepModel(1'b0, 1'b1, 12'h0);

    // Small instance: random traffic across many pointer wraps.
    $display("[TB] random traffic on DEPTH=4 instance");
    selectDut(1'b1);
    for (int i = 0; i < 100; i++) begin
      stepModel(logic'($urandom_range(0, 99) < 55),
                logic'($urandom_range(0, 99) < 50),
                12'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
